// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB requester bridge:
//   - default data/address/strobe widths and wait-state timeout
//   - apb_state_e : transfer phase encoding (IDLE, SETUP, ACCESS)
//   - crc8_xor    : XOR of every byte below the top byte of a data word
// -----------------------------------------------------------------------------
package apb_pkg;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_ADDR_WIDTH     = 8;
    localparam int DEF_STRB_WIDTH     = DEF_DATA_WIDTH / 8;
    localparam int DEF_TIMEOUT_CYCLES = 16;

    // Widest data word crc8_xor accepts; narrower words are zero-extended.
    localparam int CRC_MAX_WIDTH = 1024;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // nbytes is the real byte count of the word; the top byte is excluded
    // because that is where the check byte lives.
    function automatic logic [7:0] crc8_xor(input logic [CRC_MAX_WIDTH-1:0] data,
                                            input int nbytes);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < CRC_MAX_WIDTH / 8 - 1; i++) begin
            if (i + 1 < nbytes) begin
                acc = acc ^ data[i*8 +: 8];
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/apb_xor_crc.sv
// -----------------------------------------------------------------------------
// apb_xor_crc
// Combinational XOR check byte over all bytes of data_i except the top one.
// Used by the bridge both to generate the check byte on writes and to
// recompute it on read data.
//   data_i : DATA_WIDTH word
//   crc_o  : 8-bit XOR of data_i[DATA_WIDTH-9:0] bytes
// -----------------------------------------------------------------------------
module apb_xor_crc
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [7:0]            crc_o
);

    assign crc_o = crc8_xor(CRC_MAX_WIDTH'(data_i), DATA_WIDTH / 8);

endmodule

// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
// APB requester: accepts single-beat commands on a valid/ready port, runs one
// APB SETUP/ACCESS transfer per command and returns a one-cycle response.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o     command handshake (ready only in IDLE)
//   cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i, cmd_prot_i
//   rsp_valid_o                   one-cycle completion pulse
//   rsp_rdata_o, rsp_err_o, rsp_tmo_o   zero unless rsp_valid_o
//   sel_o, enable_o, wr_rd_o, addr_o, prot_o, wdata_o, strb_o   APB request
//   ready_i, rdata_i, err_i       APB PREADY / PRDATA / PSLVERR
//
// Build option
//   APB_MASTER_CRC_EN : writes carry an XOR check byte in the top data byte
//   (top strobe forced on); reads with a bad check byte report rsp_err.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no transfer; cmd_ready_o high, sel/enable low
// SETUP  | first APB cycle, sel high, enable low (always one cycle)
// ACCESS | sel+enable high until ready_i or wait-state timeout
// -----------------------------------------------------------------------------
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int  DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int  ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int  TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int STRB_WIDTH     = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    input  logic [STRB_WIDTH-1:0] cmd_strb_i,
    input  logic [2:0]            cmd_prot_i,

    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_tmo_o,

    output logic                  sel_o,
    output logic                  enable_o,
    output logic                  wr_rd_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [2:0]            prot_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [STRB_WIDTH-1:0] strb_o,
    input  logic                  ready_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic                  err_i
);

    localparam int             CNT_W   = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam bit             TMO_EN  = (TIMEOUT_CYCLES != 0);

    apb_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            prot_q, prot_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] strb_q, strb_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_tmo_q, rsp_tmo_d;

    logic [DATA_WIDTH-1:0] wdata_fmt;
    logic [STRB_WIDTH-1:0] strb_fmt;
    logic                  crc_bad;

`ifdef APB_MASTER_CRC_EN
    logic [7:0] crc_gen;
    logic [7:0] crc_chk;

    apb_xor_crc #(.DATA_WIDTH(DATA_WIDTH)) u_crc_gen (
        .data_i (cmd_wdata_i),
        .crc_o  (crc_gen)
    );

    apb_xor_crc #(.DATA_WIDTH(DATA_WIDTH)) u_crc_chk (
        .data_i (rdata_i),
        .crc_o  (crc_chk)
    );

    assign wdata_fmt = {crc_gen, cmd_wdata_i[DATA_WIDTH-9:0]};
    // The check byte is always written, whatever strobes the caller asked for.
    assign strb_fmt  = cmd_strb_i | {1'b1, {(STRB_WIDTH-1){1'b0}}};
    assign crc_bad   = (crc_chk != rdata_i[DATA_WIDTH-1 -: 8]);
`else
    assign wdata_fmt = cmd_wdata_i;
    assign strb_fmt  = cmd_strb_i;
    assign crc_bad   = 1'b0;
`endif

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            prot_q      <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_tmo_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            prot_q      <= prot_d;
            wdata_q     <= wdata_d;
            strb_q      <= strb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_tmo_q   <= rsp_tmo_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        prot_d      = prot_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        // Response fields default to zero so they only carry data in the pulse.
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        rsp_tmo_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    state_d = SETUP;
                    cnt_d   = '0;
                    wr_d    = cmd_write_i;
                    addr_d  = cmd_addr_i;
                    prot_d  = cmd_prot_i;
                    wdata_d = cmd_write_i ? wdata_fmt : '0;
                    strb_d  = cmd_write_i ? strb_fmt  : '0;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (ready_i) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = wr_q ? '0 : rdata_i;
                    rsp_err_d   = err_i | (~wr_q & crc_bad);
                end else if (TMO_EN) begin
                    // Counter reaches TIMEOUT_CYCLES on the last allowed wait
                    // state and stays there until the next SETUP clears it.
                    cnt_d = cnt_inc;
                    if (cnt_inc == TMO_VAL) begin
                        state_d     = IDLE;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_tmo_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_ready_o = (state_q == IDLE);
    assign sel_o       = (state_q != IDLE);
    assign enable_o    = (state_q == ACCESS);
    assign wr_rd_o     = wr_q;
    assign addr_o      = addr_q;
    assign prot_o      = prot_q;
    assign wdata_o     = wdata_q;
    assign strb_o      = strb_q;

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_tmo_o   = rsp_tmo_q;

endmodule
